full_add: RTL and testbench
===========================

FULL_ADD -- requirements
Module: full_add

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the width of the carry-event counter (legal 2..16).
REQ-002 clk  input  1  The block SHALL have a single clock, clk; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset is synchronous and active-low.
REQ-004 x  input  1  SHALL be addend bit A.
REQ-005 y  input  1  SHALL be addend bit B.
REQ-006 z  input  1  SHALL be the carry-in bit.
REQ-007 in_valid  input  1  SHALL qualify x/y/z for the current cycle.
REQ-008 clr_cnt  input  1  SHALL be a synchronous clear of carry_cnt.
REQ-009 SUM  output  1  SHALL be the registered sum bit.
REQ-010 COUT  output  1  SHALL be the registered carry-out bit.
REQ-011 out_valid  output  1  SHALL be high for one cycle when SUM/COUT hold a new result.
REQ-012 carry_cnt  output  CNT_W  SHALL be the saturating count of accepted operations with COUT=1.
REQ-013 chk_err  output  1  SHALL be the sticky self-check error flag (see Configuration).

Function
REQ-014 On a rising edge with in_valid=1, SUM SHALL load x^y^z and COUT SHALL load (x&y)|(x&z)|(y&z).
REQ-015 Latency SHALL be exactly one cycle: the result appears on the edge that samples in_valid=1, and out_valid is high for the following cycle.
REQ-016 On a rising edge with in_valid=0, SUM and COUT SHALL hold their values and out_valid SHALL load 0.
REQ-017 Back-to-back in_valid=1 cycles SHALL each produce a result, with no bubbles; out_valid stays high continuously.
REQ-018 carry_cnt SHALL increment by 1 on each accepted operation whose computed COUT is 1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 clr_cnt=1 SHALL set carry_cnt to 0 on the next edge, and SHALL win over a simultaneous increment.
REQ-021 clr_cnt SHALL NOT affect SUM, COUT, out_valid or chk_err.
REQ-022 There SHALL be no combinational path from inputs to outputs.

Reset
REQ-023 With rst_n=0 at a rising edge, SUM, COUT, out_valid and chk_err SHALL become 0, and carry_cnt SHALL become 0.
REQ-024 Reset SHALL take priority over in_valid and clr_cnt, and an operation in flight during reset SHALL be discarded.
REQ-025 The first operation SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-026 When macro FULL_ADD_SELFCHECK_EN is defined, the block SHALL register an independent arithmetic result {c,s}=x+y+z for each accepted operation.
REQ-027 With FULL_ADD_SELFCHECK_EN defined, the block SHALL set chk_err (sticky until reset) whenever out_valid=1 and {COUT,SUM} differs from the independent arithmetic result.
REQ-028 Without FULL_ADD_SELFCHECK_EN, chk_err SHALL be tied to 0, no checker logic SHALL exist, and the port SHALL remain present.

Verification
REQ-029 After reset, the bench SHALL apply x,y,z = 000,100,010,110,001,101,011,111 with in_valid=1, one per cycle; {COUT,SUM} SHALL be 00,01,01,10,01,10,10,11 one cycle later each, out_valid SHALL stay high, and carry_cnt SHALL end at 4.
REQ-030 The bench SHALL apply x=y=z=1 once, then in_valid=0 for 3 cycles; SUM=1 and COUT=1 SHALL hold, and out_valid SHALL be high one cycle then low.
REQ-031 With CNT_W=2, the bench SHALL apply 5 operations with x=y=1; carry_cnt SHALL saturate at 3.
REQ-032 The bench SHALL assert clr_cnt together with an operation whose COUT=1; carry_cnt SHALL be 0 on the next cycle.
REQ-033 The bench SHALL assert rst_n=0 in the same cycle as in_valid=1 and x=y=z=1; all outputs SHALL be 0 on the next cycle.
REQ-034 With FULL_ADD_SELFCHECK_EN defined, the bench SHALL run the exhaustive 8-combination test; chk_err SHALL remain 0.

Source files
------------

// File: rtl/full_add.sv
// -----------------------------------------------------------------------------
// full_add -- registered single-bit full adder with a saturating carry counter.
//
// Each cycle with in_valid=1, the block accepts one operation (x + y + z).
// The sum and carry-out are registered, so the result is visible one cycle
// after the accepting edge. out_valid marks each fresh result. carry_cnt
// counts accepted operations whose carry-out is 1. It saturates at all-ones
// and is cleared by clr_cnt.
//
// Optional feature macro: FULL_ADD_SELFCHECK_EN
//   When defined, the block registers an independent arithmetic result
//   {c,s} = x + y + z for every accepted operation. It raises chk_err,
//   which stays high until reset, whenever a valid output disagrees with
//   that result. When the macro is undefined, chk_err is tied to 0 and no
//   checker logic exists.
//
// Parameters
//   CNT_W      width of carry_cnt (2..16), default 8
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   x, y, z    addend A, addend B, carry-in
//   in_valid   qualifies x/y/z this cycle
//   clr_cnt    synchronous clear of carry_cnt; wins over an increment
//   SUM, COUT  registered sum / carry-out; held while in_valid=0
//   out_valid  high for one cycle per new result
//   carry_cnt  saturating count of accepted operations with COUT=1
//   chk_err    sticky self-check error (0 when the checker is not built)
// -----------------------------------------------------------------------------
module full_add #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             SUM,
  output logic             COUT,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             chk_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic sum_p0;
  logic cout_p0;

  always_comb begin
    sum_p0  = x ^ y ^ z;
    cout_p0 = (x & y) | (x & z) | (y & z);
  end

  // ---- stage p0 -> p1: result, valid and carry counter registers ----
  // SUM/COUT are cleared on reset because they are visible outputs that must
  // read 0 after reset. Reset also discards an operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SUM       <= 1'b0;
      COUT      <= 1'b0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      if (in_valid) begin
        SUM  <= sum_p0;
        COUT <= cout_p0;
      end
      out_valid <= in_valid;
      if (clr_cnt) begin
        carry_cnt <= '0;
      end else if (in_valid && cout_p0) begin
        carry_cnt <= sat_inc(carry_cnt);
      end
    end
  end

`ifdef FULL_ADD_SELFCHECK_EN
  // The reference is computed as a plain 2-bit addition, so it does not
  // share the gate-level sum/majority expressions used above.
  logic [1:0] ref_p1;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      ref_p1 <= {1'b0, x} + {1'b0, y} + {1'b0, z};
    end
  end

  // ---- stage p1 -> p2: compare the live outputs with the reference ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (out_valid && ({COUT, SUM} != ref_p1)) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_add.sv
// -----------------------------------------------------------------------------
// tb_full_add -- self-checking bench for full_add.
// Two instances share the same stimulus: the default CNT_W=8 instance and a
// CNT_W=2 instance used for saturation. A behavioural model (integer addition
// and saturating counts) predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_full_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x = 1'b0, y = 1'b0, z = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       sum8, cout8, ov8, err8;
  logic [7:0] cnt8;
  logic       sum2, cout2, ov2, err2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  // Model state
  int m_sum = 0, m_cout = 0, m_vld = 0, m_cnt8 = 0, m_cnt2 = 0;

  always #5 clk = ~clk;

  full_add dut8 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
    .in_valid(in_valid), .clr_cnt(clr_cnt),
    .SUM(sum8), .COUT(cout8), .out_valid(ov8),
    .carry_cnt(cnt8), .chk_err(err8)
  );

  full_add #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
    .in_valid(in_valid), .clr_cnt(clr_cnt),
    .SUM(sum2), .COUT(cout2), .out_valid(ov2),
    .carry_cnt(cnt2), .chk_err(err2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model and compare all outputs.
  task automatic step(input bit r, input bit iv, input bit bx, input bit by,
                      input bit bz, input bit clr);
    int total;
    rst_n    = r;
    in_valid = iv;
    x        = bx;
    y        = by;
    z        = bz;
    clr_cnt  = clr;
    @(posedge clk);
    total = int'(bx) + int'(by) + int'(bz);
    if (!r) begin
      m_sum = 0; m_cout = 0; m_vld = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (iv) begin
        m_sum  = total % 2;
        m_cout = total / 2;
      end
      m_vld = iv ? 1 : 0;
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (iv && total >= 2) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    #1;
    check("sum8",  sum8,  m_sum);
    check("cout8", cout8, m_cout);
    check("ov8",   ov8,   m_vld);
    check("cnt8",  cnt8,  m_cnt8);
    check("err8",  err8,  0);
    check("sum2",  sum2,  m_sum);
    check("cout2", cout2, m_cout);
    check("ov2",   ov2,   m_vld);
    check("cnt2",  cnt2,  m_cnt2);
    check("err2",  err2,  0);
  endtask

  initial begin
    bit [2:0] pat [8] = '{3'b000, 3'b100, 3'b010, 3'b110,
                          3'b001, 3'b101, 3'b011, 3'b111};
    int exp_cs [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    // Reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_sum",  sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_ov",   ov8, 0);
    check("rst_cnt",  cnt8, 0);

    // Exhaustive sweep, back to back; {x,y,z} given as pat[i][2:0]
    for (int i = 0; i < 8; i++) begin
      step(1, 1, pat[i][2], pat[i][1], pat[i][0], 0);
      check("exh_cs", {cout8, sum8}, exp_cs[i]);
      check("exh_ov", ov8, 1);
    end
    check("exh_cnt", cnt8, 4);
    check("exh_cnt2", cnt2, 3);

    // Hold behaviour: one op then three idle cycles
    step(1, 1, 1, 1, 1, 0);
    check("hold_ov0", ov8, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check("hold_sum", sum8, 1);
      check("hold_cout", cout8, 1);
      check("hold_ov", ov8, 0);
    end

    // Saturation on the 2-bit counter
    step(1, 0, 0, 0, 0, 1);
    check("sat_clr", cnt2, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, 0);
    check("sat_cnt2", cnt2, 3);
    check("sat_cnt8", cnt8, 5);

    // Clear wins over a simultaneous carry increment
    step(1, 1, 1, 1, 1, 1);
    check("clr_cnt8", cnt8, 0);
    check("clr_cnt2", cnt2, 0);
    check("clr_ov", ov8, 1);

    // Reset together with an operation discards it
    step(1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    check("rst_op_sum", sum8, 0);
    check("rst_op_cout", cout8, 0);
    check("rst_op_ov", ov8, 0);
    check("rst_op_cnt", cnt8, 0);
    // First edge after reset accepts an operation
    step(1, 1, 1, 0, 1, 0);
    check("first_op", {cout8, sum8}, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
